// File: rtl/spi_slave_rx_pkg.sv
// Shared encodings and widths for the SPI slave receive front end.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_WAIT_CS_HIGH
  } state_e;

  localparam int FRAME_BYTES_DEF = 17;
  localparam int BIT_CNT_W       = 3;
  localparam int BYTE_CNT_W      = 5;

endpackage

// File: rtl/spi_slave_rx_sig_sync.sv
// Multi-flop single-bit synchroniser with a selectable reset level.
module sig_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled receive with byte strobes, MISO reply shifter and frame checks.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic                  sysClk,
  input  logic                  sysRst,
  input  logic                  spiSclk,
  input  logic                  spiCs_n,
  input  logic                  spiMosi,
  output logic                  spiMiso,
  output logic                  spiMiso_oe,
  input  logic [7:0]            tx_data,
  output logic                  tx_load,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic                  frame_err
);

  logic sclk_s, cs_n_s, mosi_s;

  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(sysClk), .srst(sysRst), .d(spiSclk), .q(sclk_s)
  );
  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(sysClk), .srst(sysRst), .d(spiCs_n), .q(cs_n_s)
  );
  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(sysClk), .srst(sysRst), .d(spiMosi), .q(mosi_s)
  );

  state_e                state_q, state_d;
  logic                  sclk_hist_q, sclk_hist_d;
  logic                  cs_hist_q, cs_hist_d;
  logic [SYNC_STAGES:0]  settle_q, settle_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [6:0]            tx_shift_q, tx_shift_d;
  logic                  tx_load_q, tx_load_d;
  logic                  miso_q, miso_d;
  logic                  skip_fall_q, skip_fall_d;
  logic                  frame_active_q, frame_active_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_n_s & cs_hist_q;
  assign cs_rise   = cs_n_s & ~cs_hist_q;

  always_comb begin
    state_d        = state_q;
    sclk_hist_d    = sclk_s;
    cs_hist_d      = cs_n_s;
    settle_d       = {settle_q[SYNC_STAGES-1:0], 1'b1};
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_byte_d      = rx_byte_q;
    rx_valid_d     = 1'b0;
    tx_shift_d     = tx_shift_q;
    tx_load_d      = 1'b0;
    miso_d         = miso_q;
    skip_fall_d    = skip_fall_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      // Hold off until the synchronisers have flushed their reset value, so a
      // CS that was already low at reset release is never seen as a new frame.
      ST_WAIT_CS_HIGH: begin
        if (settle_q[SYNC_STAGES] && cs_n_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (cs_fall) begin
          state_d        = ST_ACTIVE;
          bit_cnt_d      = '0;
          byte_cnt_d     = '0;
          rx_shift_d     = '0;
          tx_shift_d     = tx_data[6:0];
          tx_load_d      = 1'b1;
          miso_d         = tx_data[7];
          skip_fall_d    = 1'b0;
          frame_active_d = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            rx_byte_d   = {rx_shift_q, mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            if (byte_cnt_q != {BYTE_CNT_W{1'b1}}) begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
            tx_shift_d  = tx_data[6:0];
            tx_load_d   = 1'b1;
            miso_d      = tx_data[7];
            skip_fall_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (skip_fall_q) begin
            skip_fall_d = 1'b0;
          end else begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
          end
        end

        // Judged on the post-update counters so a byte completing together
        // with CS rising is counted.
        if (cs_rise) begin
          state_d        = ST_IDLE;
          frame_active_d = 1'b0;
          miso_d         = 1'b0;
          if (bit_cnt_d != '0) begin
            frame_err_d = 1'b1;
          end else if (byte_cnt_d == BYTE_CNT_W'(FRAME_BYTES)) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          bit_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_WAIT_CS_HIGH;
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_q        <= ST_WAIT_CS_HIGH;
      sclk_hist_q    <= 1'b0;
      cs_hist_q      <= 1'b1;
      settle_q       <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      rx_shift_q     <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_shift_q     <= '0;
      tx_load_q      <= 1'b0;
      miso_q         <= 1'b0;
      skip_fall_q    <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_hist_q    <= sclk_hist_d;
      cs_hist_q      <= cs_hist_d;
      settle_q       <= settle_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      tx_shift_q     <= tx_shift_d;
      tx_load_q      <= tx_load_d;
      miso_q         <= miso_d;
      skip_fall_q    <= skip_fall_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign spiMiso      = miso_q;
  assign spiMiso_oe   = frame_active_q;
  assign tx_load      = tx_load_q;
  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign byte_cnt     = byte_cnt_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of CS frames plus hand-written corner sequences.
module tb_spi_slave_rx;

  logic       sysClk = 1'b0;
  logic       sysRst = 1'b1;
  logic       spiSclk = 1'b0;
  logic       spiCs_n = 1'b1;
  logic       spiMosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       spiMiso, spiMiso_oe, tx_load, rx_valid;
  logic       frame_active, frame_done, frame_err;
  logic [7:0] rx_byte;
  logic [4:0] byte_cnt;

  always #5 sysClk = ~sysClk;

  spi_slave_rx #(.SYNC_STAGES(2), .FRAME_BYTES(17)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .spiSclk(spiSclk), .spiCs_n(spiCs_n),
    .spiMosi(spiMosi), .spiMiso(spiMiso), .spiMiso_oe(spiMiso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .byte_cnt(byte_cnt), .frame_active(frame_active), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_q[$];
  int         n_load, n_done, n_err;
  bit         oe_seen;

  always @(negedge sysClk) begin
    if (!sysRst) begin
      if (rx_valid) rx_q.push_back(rx_byte);
      if (tx_load) n_load++;
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (spiMiso_oe) oe_seen = 1'b1;
    end
  end

  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2, fill, tx;
    int         nfull;
    int         nbits;
    int         exp_done;
    int         exp_err;
  } frame_t;

  frame_t tbl[6];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    n_load  = 0;
    n_done  = 0;
    n_err   = 0;
    oe_seen = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input frame_t f, input int i);
    if (i == 0) return f.b0;
    if (i == 1) return f.b1;
    if (i == 2) return f.b2;
    return f.fill;
  endfunction

  // SCLK at sysClk/8: 40 ns per half period; MISO sampled on the raw rising edge.
  task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] mb);
    mb = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spiMosi = b[7-i];
      #40;
      spiSclk = 1'b1;
      mb[7-i] = spiMiso;
      #40;
      spiSclk = 1'b0;
    end
  endtask

  task automatic run_frame(input frame_t f);
    logic [7:0] mb;
    int         exp_cnt;
    clear_mon();
    tx_data = f.tx;
    spiCs_n = 1'b0;
    #80;
    for (int i = 0; i < f.nfull; i++) begin
      send_bits(byte_of(f, i), 8, mb);
      check({f.name, " miso byte"}, int'(mb), int'(f.tx));
      if (i == 0) check({f.name, " oe while active"}, int'(spiMiso_oe), 1);
    end
    if (f.nbits > 0) send_bits(byte_of(f, f.nfull), f.nbits, mb);
    #40;
    spiCs_n = 1'b1;
    #120;
    check({f.name, " rx count"}, rx_q.size(), f.nfull);
    for (int i = 0; i < f.nfull && i < rx_q.size(); i++)
      check({f.name, " rx byte"}, int'(rx_q[i]), int'(byte_of(f, i)));
    exp_cnt = (f.nfull > 31) ? 31 : f.nfull;
    check({f.name, " byte_cnt"}, int'(byte_cnt), exp_cnt);
    check({f.name, " frame_done"}, n_done, f.exp_done);
    check({f.name, " frame_err"}, n_err, f.exp_err);
    check({f.name, " tx_load"}, n_load, 1 + f.nfull);
    check({f.name, " oe after cs"}, int'(spiMiso_oe), 0);
    check({f.name, " frame_active"}, int'(frame_active), 0);
    $display("frame %s: bytes=%0d rx=%0d done=%0d err=%0d loads=%0d",
             f.name, f.nfull, rx_q.size(), n_done, n_err, n_load);
  endtask

  logic [7:0] mb_g;

  initial begin
    tbl[0] = '{"full17",   8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 17, 0, 1, 0};
    tbl[1] = '{"short3",   8'h07, 8'h12, 8'h34, 8'h00, 8'hE1,  3, 0, 0, 1};
    tbl[2] = '{"partial",  8'h5A, 8'hFF, 8'h00, 8'h00, 8'h96,  1, 5, 0, 1};
    tbl[3] = '{"full17b",  8'h80, 8'h7F, 8'hC3, 8'hC3, 8'h81, 17, 0, 1, 0};
    tbl[4] = '{"long18",   8'hFF, 8'h00, 8'h55, 8'hAA, 8'h0F, 18, 0, 0, 1};
    tbl[5] = '{"empty",    8'h00, 8'h00, 8'h00, 8'h00, 8'h42,  0, 0, 0, 1};
    clear_mon();

    repeat (4) @(posedge sysClk);
    #1;
    check("reset rx_byte", int'(rx_byte), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset byte_cnt", int'(byte_cnt), 0);
    check("reset miso/oe/active", int'({spiMiso, spiMiso_oe, frame_active}), 0);
    check("reset pulses", int'({tx_load, frame_done, frame_err}), 0);
    sysRst = 1'b0;
    repeat (10) @(posedge sysClk);
    #1;

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    // SCLK activity with CS high must be ignored entirely.
    clear_mon();
    for (int i = 0; i < 16; i++) begin
      #40 spiSclk = ~spiSclk;
    end
    #120;
    check("cs high rx", rx_q.size(), 0);
    check("cs high pulses", n_load + n_done + n_err, 0);
    check("cs high oe", int'(oe_seen), 0);
    $display("seq sclk-with-cs-high: rx=%0d loads=%0d oe_seen=%0d", rx_q.size(), n_load, oe_seen);

    // Last SCLK rise of byte 17 coincides with CS rising.
    clear_mon();
    tx_data = 8'h3C;
    spiCs_n = 1'b0;
    #80;
    for (int i = 0; i < 16; i++) send_bits(8'h11, 8, mb_g);
    send_bits(8'hC7, 7, mb_g);
    spiMosi = 1'b1;
    #40;
    spiSclk = 1'b1;
    spiCs_n = 1'b1;
    #40;
    spiSclk = 1'b0;
    #120;
    check("simul rx count", rx_q.size(), 17);
    if (rx_q.size() == 17) check("simul last byte", int'(rx_q[16]), 8'hC7);
    check("simul done", n_done, 1);
    check("simul err", n_err, 0);
    $display("seq simultaneous-cs: rx=%0d done=%0d err=%0d", rx_q.size(), n_done, n_err);

    // Reset in the middle of a frame: nothing delivered until CS cycles high/low.
    clear_mon();
    tx_data = 8'h55;
    spiCs_n = 1'b0;
    #80;
    for (int i = 0; i < 6; i++) send_bits(8'h5C, 8, mb_g);
    check("pre-reset rx count", rx_q.size(), 6);
    @(posedge sysClk);
    #1 sysRst = 1'b1;
    repeat (3) @(posedge sysClk);
    #1 sysRst = 1'b0;
    check("reset mid byte_cnt", int'(byte_cnt), 0);
    clear_mon();
    for (int i = 0; i < 11; i++) send_bits(8'h3A, 8, mb_g);
    check("after reset active", int'(frame_active), 0);
    check("after reset rx", rx_q.size(), 0);
    check("after reset loads", n_load, 0);
    spiCs_n = 1'b1;
    #120;
    check("after reset pulses", n_done + n_err, 0);
    check("after reset oe", int'(oe_seen), 0);
    $display("seq reset-mid-frame: rx=%0d loads=%0d done=%0d err=%0d",
             rx_q.size(), n_load, n_done, n_err);
    run_frame(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
